dfi_resp_model: RTL and testbench



---
 rtl/dfi_resp_pkg.sv | 51 +++++
 rtl/dfi_resp_model_cmdq.sv | 56 +++++
 rtl/dfi_resp_model.sv | 191 +++++++++++++++++++
 tb/tb_dfi_resp_model.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfi_resp_pkg.sv
// dfi_resp_model shared types: DFI widths, command decode, queue entry.
// Column/beat widths here describe the default build.
package dfi_resp_pkg;

  localparam int DFI_CS_WIDTH   = 1;
  localparam int DFI_BA_WIDTH   = 3;
  localparam int DFI_ADDR_WIDTH = 14;
  localparam int BURST_BEATS_D  = 2;
  localparam int COL_BITS_D     = 4;

  localparam int IDX_W  = DFI_BA_WIDTH + COL_BITS_D;
  localparam int BEAT_W =
    (BURST_BEATS_D > 1) ? $clog2(BURST_BEATS_D) : 1;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_REF,
    CMD_RD,
    CMD_WR
  } cmd_e;

  typedef struct packed {
    logic [DFI_BA_WIDTH-1:0] ba;
    logic [COL_BITS_D-1:0]   col;
  } qent_t;

  function automatic cmd_e decode_cmd(
    input logic cke,
    input logic cs_n0,
    input logic ras_n,
    input logic cas_n,
    input logic we_n
  );
    cmd_e c;
    c = CMD_NOP;
    if (cke && !cs_n0) begin
      unique case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACT;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_REF;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dfi_resp_model_cmdq.sv
// Small synchronous command FIFO holding {ba, col} entries.
// A push while full is dropped even if a pop happens the same cycle.
module dfi_resp_cmdq
  import dfi_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  qent_t din,
  output logic  full,
  input  logic  pop,
  output qent_t dout,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  qent_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic do_push;
  logic do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (do_pop)
        rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dfi_resp_model.sv
// Far-end DFI responder: bank-open checks, write store, read return.
// DFI_RESP_MASK_EN: honour wrdata_mask (1 = keep old byte).
module dfi_resp_model
  import dfi_resp_pkg::*;
#(
  parameter int BURST_BEATS = BURST_BEATS_D,
  parameter int COL_BITS    = COL_BITS_D,
  parameter int RDDATA_LAT  = 2,
  parameter int QDEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cke,
  input  logic [DFI_CS_WIDTH-1:0]   cs_n,
  input  logic                      ras_n,
  input  logic                      cas_n,
  input  logic                      we_n,
  input  logic [DFI_BA_WIDTH-1:0]   ba,
  input  logic [DFI_ADDR_WIDTH-1:0] addr,
  input  logic                      odt,
  input  logic                      wrdata_en,
  input  logic [127:0]              wrdata,
  input  logic [15:0]               wrdata_mask,
  input  logic                      rddata_en,
  output logic [127:0]              rddata,
  output logic                      rddata_valid,
  output logic [15:0]               rddata_dnv,
  output logic                      err_proto,
  output logic                      err_q_ovf,
  output logic                      err_wr_unf,
  output logic                      err_rd_unf
);

  localparam int NBANK = 1 << DFI_BA_WIDTH;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    BEAT_W'(BURST_BEATS - 1);
  localparam logic [COL_BITS-1:0] COL_KEEP =
    ~(COL_BITS'(BURST_BEATS - 1));

  cmd_e  cmd;
  qent_t cmd_ent;
  logic [NBANK-1:0] open_q;

  logic  rq_push, rq_pop, rq_full, rq_empty;
  logic  wq_push, wq_pop, wq_full, wq_empty;
  qent_t rq_head, wq_head;

  logic [BEAT_W-1:0] wbeat, rbeat;
  logic [IDX_W-1:0]  widx, ridx;
  logic              wr_fire, rd_hit;
  logic [15:0]       wr_be;
  logic [127:0]      rd_word;
  logic              unused_ok;

  assign cmd = decode_cmd(cke, cs_n[0], ras_n, cas_n, we_n);
  assign cmd_ent.ba  = ba;
  assign cmd_ent.col = addr[COL_BITS-1:0] & COL_KEEP;

  assign rq_push = (cmd == CMD_RD);
  assign wq_push = (cmd == CMD_WR);

  dfi_resp_cmdq #(.DEPTH(QDEPTH)) u_rdq (
    .clk   (clk),
    .rst   (rst),
    .push  (rq_push),
    .din   (cmd_ent),
    .full  (rq_full),
    .pop   (rq_pop),
    .dout  (rq_head),
    .empty (rq_empty)
  );

  dfi_resp_cmdq #(.DEPTH(QDEPTH)) u_wrq (
    .clk   (clk),
    .rst   (rst),
    .push  (wq_push),
    .din   (cmd_ent),
    .full  (wq_full),
    .pop   (wq_pop),
    .dout  (wq_head),
    .empty (wq_empty)
  );

`ifdef DFI_RESP_MASK_EN
  assign wr_be = ~wrdata_mask;
`else
  assign wr_be = '1;
`endif

  assign unused_ok = ^{odt, addr, cs_n, wrdata_mask};

  assign wr_fire = wrdata_en && !wq_empty && !rst;
  assign rd_hit  = rddata_en && !rq_empty;
  assign wq_pop  = wr_fire && (wbeat == BEAT_LAST);
  assign rq_pop  = rd_hit && (rbeat == BEAT_LAST);

  assign widx = {wq_head.ba, wq_head.col} + IDX_W'(wbeat);
  assign ridx = {rq_head.ba, rq_head.col} + IDX_W'(rbeat);

  logic [127:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_be[b]) mem[widx][8*b +: 8] <= wrdata[8*b +: 8];
      end
    end
  end

  // write-first: a same-cycle beat to the read entry is forwarded
  always_comb begin
    rd_word = mem[ridx];
    if (wr_fire && (widx == ridx)) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wrdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbeat <= '0;
      rbeat <= '0;
    end else begin
      if (wr_fire)
        wbeat <= (wbeat == BEAT_LAST) ? '0 : wbeat + 1'b1;
      if (rd_hit)
        rbeat <= (rbeat == BEAT_LAST) ? '0 : rbeat + 1'b1;
    end
  end

  logic [RDDATA_LAT-1:0] pv;
  logic [127:0]          pd [RDDATA_LAT];
  logic [15:0]           pm [RDDATA_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RDDATA_LAT; i++) begin
        pd[i] <= '0;
        pm[i] <= '0;
      end
    end else begin
      pv[0] <= rddata_en;
      pd[0] <= rd_hit ? rd_word : '0;
      pm[0] <= (rddata_en && rq_empty) ? '1 : '0;
      for (int i = 1; i < RDDATA_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pm[i] <= pm[i-1];
      end
    end
  end

  assign rddata_valid = pv[RDDATA_LAT-1];
  assign rddata       = pd[RDDATA_LAT-1];
  assign rddata_dnv   = pm[RDDATA_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
    end else if (cmd == CMD_ACT) begin
      open_q[ba] <= 1'b1;
    end else if (cmd == CMD_PRE) begin
      if (addr[10]) open_q <= '0;
      else          open_q[ba] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_proto  <= 1'b0;
      err_q_ovf  <= 1'b0;
      err_wr_unf <= 1'b0;
      err_rd_unf <= 1'b0;
    end else begin
      if ((rq_push || wq_push) && !open_q[ba])
        err_proto <= 1'b1;
      if ((cmd == CMD_REF) && (|open_q))
        err_proto <= 1'b1;
      if ((rq_push && rq_full) || (wq_push && wq_full))
        err_q_ovf <= 1'b1;
      if (wrdata_en && wq_empty)
        err_wr_unf <= 1'b1;
      if (rddata_en && rq_empty)
        err_rd_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dfi_resp_model.sv
// Directed + random bench for dfi_resp_model against a queue model.
// Honours DFI_RESP_MASK_EN the same way as the design build.
module tb_dfi_resp_model;
  import dfi_resp_pkg::*;

  localparam int LAT = 2;
  localparam int QD  = 4;
  localparam int BB  = 2;
`ifdef DFI_RESP_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_NOP = 3'b111;

  logic clk = 1'b0;
  logic rst, cke, ras_n, cas_n, we_n, odt;
  logic [DFI_CS_WIDTH-1:0]   cs_n;
  logic [DFI_BA_WIDTH-1:0]   ba;
  logic [DFI_ADDR_WIDTH-1:0] addr;
  logic wrdata_en, rddata_en;
  logic [127:0] wrdata;
  logic [15:0]  wrdata_mask;
  logic [127:0] rddata;
  logic rddata_valid;
  logic [15:0] rddata_dnv;
  logic err_proto, err_q_ovf, err_wr_unf, err_rd_unf;

  dfi_resp_model #(
    .BURST_BEATS (BB),
    .COL_BITS    (4),
    .RDDATA_LAT  (LAT),
    .QDEPTH      (QD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cke          (cke),
    .cs_n         (cs_n),
    .ras_n        (ras_n),
    .cas_n        (cas_n),
    .we_n         (we_n),
    .ba           (ba),
    .addr         (addr),
    .odt          (odt),
    .wrdata_en    (wrdata_en),
    .wrdata       (wrdata),
    .wrdata_mask  (wrdata_mask),
    .rddata_en    (rddata_en),
    .rddata       (rddata),
    .rddata_valid (rddata_valid),
    .rddata_dnv   (rddata_dnv),
    .err_proto    (err_proto),
    .err_q_ovf    (err_q_ovf),
    .err_wr_unf   (err_wr_unf),
    .err_rd_unf   (err_rd_unf)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: bank flags, command queues, byte memory
  typedef struct {
    int           due;
    logic [127:0] d;
    logic [15:0]  dnv;
    logic [127:0] known;
  } rexp_t;

  bit           open_m [8];
  int           rq [$];
  int           wq [$];
  int           wb, rb, ncyc;
  logic [127:0] mm [128];
  bit   [15:0]  km [128];
  bit           e_proto, e_ovf, e_wunf, e_runf;
  rexp_t        rx [$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) open_m[i] = 0;
    rq.delete();
    wq.delete();
    rx.delete();
    wb = 0;
    rb = 0;
    e_proto = 0;
    e_ovf = 0;
    e_wunf = 0;
    e_runf = 0;
  endtask

  task automatic model_step();
    bit rqf, wqf, any;
    int ent, i;
    rexp_t r;
    if (rst) begin
      model_reset();
      return;
    end
    rqf = (rq.size() == QD);
    wqf = (wq.size() == QD);
    ent = int'(ba) * 16 + (int'(addr[3:0]) / BB) * BB;
    if (wrdata_en) begin
      if (wq.size() == 0) e_wunf = 1;
      else begin
        i = wq[0] + wb;
        for (int b = 0; b < 16; b++) begin
          if (!(MASK_EN && wrdata_mask[b])) begin
            mm[i][8*b +: 8] = wrdata[8*b +: 8];
            km[i][b] = 1'b1;
          end
        end
        wb++;
        if (wb == BB) begin
          wb = 0;
          void'(wq.pop_front());
        end
      end
    end
    if (rddata_en) begin
      r.due = ncyc + LAT - 1;
      if (rq.size() == 0) begin
        e_runf = 1;
        r.d = '0;
        r.dnv = '1;
        r.known = '1;
      end else begin
        i = rq[0] + rb;
        r.d = mm[i];
        r.dnv = '0;
        for (int b = 0; b < 16; b++)
          r.known[8*b +: 8] = {8{km[i][b]}};
        rb++;
        if (rb == BB) begin
          rb = 0;
          void'(rq.pop_front());
        end
      end
      rx.push_back(r);
    end
    if (cke && !cs_n[0]) begin
      any = 0;
      for (int k = 0; k < 8; k++) any |= open_m[k];
      case ({ras_n, cas_n, we_n})
        C_ACT: open_m[ba] = 1;
        C_PRE: begin
          if (addr[10])
            for (int k = 0; k < 8; k++) open_m[k] = 0;
          else open_m[ba] = 0;
        end
        C_REF: if (any) e_proto = 1;
        C_RD: begin
          if (!open_m[ba]) e_proto = 1;
          if (rqf) e_ovf = 1;
          else rq.push_back(ent);
        end
        C_WR: begin
          if (!open_m[ba]) e_proto = 1;
          if (wqf) e_ovf = 1;
          else wq.push_back(ent);
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("err_proto",  128'(err_proto),  128'(e_proto));
    check("err_q_ovf",  128'(err_q_ovf),  128'(e_ovf));
    check("err_wr_unf", 128'(err_wr_unf), 128'(e_wunf));
    check("err_rd_unf", 128'(err_rd_unf), 128'(e_runf));
    if (rx.size() > 0 && rx[0].due == ncyc) begin
      check("rd_valid", 128'(rddata_valid), 128'(1));
      check("rd_data", rddata & rx[0].known,
            rx[0].d & rx[0].known);
      check("rd_dnv", 128'(rddata_dnv), 128'(rx[0].dnv));
      void'(rx.pop_front());
    end else begin
      check("rd_idle", 128'(rddata_valid), 128'(0));
    end
    ncyc++;
  endtask

  task automatic idle();
    rst = 0;
    cke = 1;
    cs_n = '0;
    {ras_n, cas_n, we_n} = C_NOP;
    ba = '0;
    addr = '0;
    odt = 0;
    wrdata_en = 0;
    wrdata = '0;
    wrdata_mask = '0;
    rddata_en = 0;
  endtask

  task automatic cmd(input logic [2:0] c, input int b, input int col);
    idle();
    {ras_n, cas_n, we_n} = c;
    ba = DFI_BA_WIDTH'(b);
    addr = DFI_ADDR_WIDTH'(col);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    cyc();
    idle();
  endtask

  task automatic beat(input logic [127:0] d, input logic [15:0] m);
    idle();
    wrdata_en = 1;
    wrdata = d;
    wrdata_mask = m;
    cyc();
  endtask

  task automatic rd_en();
    idle();
    rddata_en = 1;
    cyc();
  endtask

  localparam logic [127:0] A0 = {16{8'h11}};
  localparam logic [127:0] A1 = {16{8'h22}};

  initial begin
    int nv;
    logic [127:0] exp_m;
    ncyc = 0;
    model_reset();
    do_reset();
    check("rst_data", rddata, 128'(0));
    check("rst_dnv", 128'(rddata_dnv), 128'(0));

    // basic write then read of one burst
    cmd(C_ACT, 1, 0); cyc();
    cmd(C_WR, 1, 4); cyc();
    beat(A0, '0);
    beat(A1, '0);
    cmd(C_RD, 1, 4); cyc();
    rd_en();
    rd_en();
    check("t1_a0", rddata, A0);
    check("t1_v0", 128'(rddata_valid), 128'(1));
    idle(); cyc();
    check("t1_a1", rddata, A1);
    check("t1_v1", 128'(rddata_valid), 128'(1));
    idle(); cyc();
    check("t1_end", 128'(rddata_valid), 128'(0));
    check("t1_flags", 128'({err_proto, err_q_ovf,
                            err_wr_unf, err_rd_unf}), 128'(0));

    // protocol errors
    cmd(C_RD, 3, 0); cyc();
    check("t2_closed", 128'(err_proto), 128'(1));
    idle(); cyc();
    check("t2_sticky", 128'(err_proto), 128'(1));
    do_reset();
    cmd(C_ACT, 1, 0); cyc();
    cmd(C_REF, 0, 0); cyc();
    check("t2_ref", 128'(err_proto), 128'(1));

    // RD queue overflow
    do_reset();
    cmd(C_ACT, 2, 0); cyc();
    for (int k = 0; k < 5; k++) begin
      cmd(C_RD, 2, 2 * k); cyc();
    end
    check("t3_ovf", 128'(err_q_ovf), 128'(1));
    nv = 0;
    for (int k = 0; k < 8 + LAT; k++) begin
      idle();
      rddata_en = (k < 8);
      cyc();
      nv += int'(rddata_valid);
    end
    check("t3_beats", 128'(nv), 128'(8));
    check("t3_runf", 128'(err_rd_unf), 128'(0));

    // RD underflow
    do_reset();
    rd_en();
    idle(); cyc();
    check("t4_valid", 128'(rddata_valid), 128'(1));
    check("t4_dnv", 128'(rddata_dnv), 128'(16'hFFFF));
    check("t4_data", rddata, 128'(0));
    check("t4_unf", 128'(err_rd_unf), 128'(1));

    // byte mask: low 8 bytes masked on the overwrite
    do_reset();
    cmd(C_ACT, 0, 0); cyc();
    cmd(C_WR, 0, 0); cyc();
    beat('1, '0);
    beat('1, '0);
    cmd(C_WR, 0, 0); cyc();
    beat('0, 16'h00FF);
    beat('0, 16'h00FF);
    cmd(C_RD, 0, 0); cyc();
    rd_en();
    rd_en();
    exp_m = MASK_EN ? {64'h0, {8{8'hFF}}} : 128'h0;
    check("t5_mask", rddata, exp_m);

    // reset during the second read beat
    do_reset();
    cmd(C_ACT, 1, 0); cyc();
    cmd(C_WR, 1, 8); cyc();
    beat(A1, '0);
    beat(A0, '0);
    cmd(C_RD, 1, 8); cyc();
    rd_en();
    idle();
    rddata_en = 1;
    rst = 1;
    cyc();
    check("t6_valid", 128'(rddata_valid), 128'(0));
    check("t6_flags", 128'({err_proto, err_q_ovf,
                            err_wr_unf, err_rd_unf}), 128'(0));
    rd_en();
    idle(); cyc();
    check("t6_qempty", 128'(rddata_dnv), 128'(16'hFFFF));

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      idle();
      rst = ($urandom_range(0, 199) == 0);
      cke = ($urandom_range(0, 15) != 0);
      cs_n[0] = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      case (r)
        2: {ras_n, cas_n, we_n} = C_ACT;
        3: {ras_n, cas_n, we_n} = C_PRE;
        4: {ras_n, cas_n, we_n} = C_REF;
        5, 6: {ras_n, cas_n, we_n} = C_RD;
        7, 8: {ras_n, cas_n, we_n} = C_WR;
        9: {ras_n, cas_n, we_n} = 3'b000;
        default: {ras_n, cas_n, we_n} = C_NOP;
      endcase
      ba = DFI_BA_WIDTH'($urandom_range(0, 7));
      addr = DFI_ADDR_WIDTH'($urandom);
      odt = 1'($urandom_range(0, 1));
      wrdata_en = 1'($urandom_range(0, 1));
      wrdata = {$urandom, $urandom, $urandom, $urandom};
      wrdata_mask = 16'($urandom);
      rddata_en = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();
    for (int k = 0; k < LAT + 1; k++) cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
